// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder datapath.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full-adder cell; sum built from two XNOR stages so it maps onto XNOR-based cells later.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ab_xnor;

    assign ab_xnor = ~(a ^ b);
    assign s       = ~(ab_xnor ^ ci);
    assign co      = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one fa_cell time-shared over WIDTH bits, LSB first.
// Handshake: an addition is accepted on a rising edge where ready=1 and start=1; done pulses for one cycle when sum/cout are valid.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_t    state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q;
    logic             s_bit, c_bit;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_q <= {s_bit, sum_q[WIDTH-1:1]};
                    carry <= c_bit;
                    // Hold at LAST instead of wrapping; the next accept reloads it anyway.
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                    if (cnt == LAST) cout_q <= c_bit;
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: timing, handshake, reset and a strided operand sweep.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       ready, busy, done;
    logic [7:0] sum;
    logic       cout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one addition, then watch a fixed 12-cycle window (outputs sampled on negedge).
    // If inj > 0, start is re-asserted with different operands at window cycle inj.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int inj,
                          output logic [7:0] rs, output logic rc,
                          output int busy_n, output int done_n, output int done_lat);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc;
        busy_n = 0; done_n = 0; done_lat = -1; rs = '0; rc = 1'b0;
        for (int lat = 1; lat <= 12; lat++) begin
            @(negedge clk);
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom); cin = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_lat < 0) begin
                    done_lat = lat; rs = sum; rc = cout;
                end
            end
            if (lat == inj) begin
                start = 1'b1; a = ~ta; b = ~tb; cin = ~tc;
            end
        end
    endtask

    typedef struct {
        logic [7:0] va, vb;
        logic       vc;
        logic [8:0] exp;
        int         inj;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] rs;
        logic       rc;
        int         busy_n, done_n, done_lat;
        int         acc, dn, first_acc, second_acc;
        logic [8:0] want;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 9'h096, 0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 9'h100, 0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 9'h101, 0};
        vecs[4] = '{8'h5A, 8'h3C, 1'b0, 9'h096, 2};

        // Clock/reset
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sum",   32'(sum),   32'd0);
        check("rst_cout",  32'(cout),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, including start re-asserted mid-RUN (vecs[4])
        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].inj, rs, rc, busy_n, done_n, done_lat);
            check($sformatf("vec%0d_result", i), 32'({rc, rs}), 32'(vecs[i].exp));
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
            check($sformatf("vec%0d_done_pulses", i), 32'(done_n), 32'd1);
            check($sformatf("vec%0d_done_latency", i), 32'(done_lat), 32'd9);
            check($sformatf("vec%0d_idle_ready", i), 32'(ready), 32'd1);
        end

        // start held high: accepted only from IDLE, one op every 10 cycles
        @(negedge clk);
        check("hold_ready_at_entry", 32'(ready), 32'd1);
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b1;
        acc = 0; dn = 0; first_acc = -1; second_acc = -1;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) @(negedge clk);
            if (ready) begin
                acc++;
                if (first_acc < 0) first_acc = j;
                else if (second_acc < 0) second_acc = j;
            end
            if (done) begin
                dn++;
                check("hold_result", 32'({cout, sum}), 32'h101);
            end
        end
        start = 1'b0;
        check("hold_accepts", 32'(acc), 32'd4);
        check("hold_dones",   32'(dn),  32'd4);
        check("hold_spacing", 32'(second_acc - first_acc), 32'd10);
        repeat (2) @(negedge clk);

        // Reset landing on E4 of an addition discards it
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        check("midrst_sum",   32'(sum),   32'd0);
        check("midrst_cout",  32'(cout),  32'd0);
        dn = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midrst_no_done", 32'(dn), 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 0, rs, rc, busy_n, done_n, done_lat);
        check("post_rst_result", 32'({rc, rs}), 32'h046);
        check("post_rst_done_pulses", 32'(done_n), 32'd1);

        // Strided sweep of operand space against a+b+cin
        for (int ai = 0; ai < 18; ai++) begin
            for (int bi = 0; bi < 18; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    want = 9'(ai * 15) + 9'(bi * 15) + 9'(c);
                    run_op(8'(ai * 15), 8'(bi * 15), 1'(c), 0, rs, rc, busy_n, done_n, done_lat);
                    check($sformatf("sweep_%0d_%0d_%0d", ai * 15, bi * 15, c), 32'({rc, rs}), 32'(want));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
